// File: rtl/vga_sync_gen.sv
// VGA raster timing generator.
// Free-running column/row counters plus active-video flags and active-low
// porched sync pulses. All six outputs are registered and describe the same
// pixel position in every cycle.
module vga_sync_gen #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2,
  parameter int CNT_W         = 10
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_H_Active,
  output logic             o_V_Active,
  output logic             o_H_Sync,
  output logic             o_V_Sync
);

  // Boundaries are held one bit wider than the counters so that a sync
  // window ending exactly at the line/frame total cannot overflow.
  localparam logic [CNT_W:0] COL_LAST   = (CNT_W+1)'(TOTAL_COLS - 1);
  localparam logic [CNT_W:0] ROW_LAST   = (CNT_W+1)'(TOTAL_ROWS - 1);
  localparam logic [CNT_W:0] H_ACT_END  = (CNT_W+1)'(ACTIVE_COLS);
  localparam logic [CNT_W:0] V_ACT_END  = (CNT_W+1)'(ACTIVE_ROWS);
  localparam logic [CNT_W:0] HS_START   = (CNT_W+1)'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CNT_W:0] HS_END     = (CNT_W+1)'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [CNT_W:0] VS_START   = (CNT_W+1)'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [CNT_W:0] VS_END     = (CNT_W+1)'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

  logic [CNT_W-1:0] col_reg, col_next;
  logic [CNT_W-1:0] row_reg, row_next;
  logic             h_active_reg, h_active_next;
  logic             v_active_reg, v_active_next;
  logic             h_sync_reg, h_sync_next;
  logic             v_sync_reg, v_sync_next;
  logic             col_wrap;
  logic             row_wrap;

  // Next raster position: column advances every clock, row only on column wrap.
  always_comb begin
    col_wrap = ({1'b0, col_reg} == COL_LAST);
    row_wrap = ({1'b0, row_reg} == ROW_LAST);
    col_next = col_wrap ? '0 : col_reg + 1'b1;
    row_next = row_reg;
    if (col_wrap) begin
      row_next = row_wrap ? '0 : row_reg + 1'b1;
    end
  end

  // Decode the next position so flags land in the same cycle as the counts.
  always_comb begin
    h_active_next = ({1'b0, col_next} < H_ACT_END);
    v_active_next = ({1'b0, row_next} < V_ACT_END);
    h_sync_next   = !(({1'b0, col_next} >= HS_START) && ({1'b0, col_next} < HS_END));
    v_sync_next   = !(({1'b0, row_next} >= VS_START) && ({1'b0, row_next} < VS_END));
  end

  // Raster state registers; reset state equals the decode of position 0/0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_reg      <= '0;
      row_reg      <= '0;
      h_active_reg <= 1'b1;
      v_active_reg <= 1'b1;
      h_sync_reg   <= 1'b1;
      v_sync_reg   <= 1'b1;
    end else begin
      col_reg      <= col_next;
      row_reg      <= row_next;
      h_active_reg <= h_active_next;
      v_active_reg <= v_active_next;
      h_sync_reg   <= h_sync_next;
      v_sync_reg   <= v_sync_next;
    end
  end

  assign o_Col_Count = col_reg;
  assign o_Row_Count = row_reg;
  assign o_H_Active  = h_active_reg;
  assign o_V_Active  = v_active_reg;
  assign o_H_Sync    = h_sync_reg;
  assign o_V_Sync    = v_sync_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen using a reduced raster so that several
// whole frames fit in a short run. Expected pixels come from a linear pixel
// index model; a monitor compares every cycle and also measures sync periods.
module tb_vga_sync_gen;

  localparam int TC    = 100;
  localparam int TR    = 50;
  localparam int AC    = 80;
  localparam int AR    = 40;
  localparam int HFP   = 4;
  localparam int HSW   = 8;
  localparam int VFP   = 3;
  localparam int VSW   = 2;
  localparam int CW    = 8;
  localparam int FRAME = TC * TR;

  logic          CLK = 1'b0;
  logic          RST;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          ha, va, hs, vs;

  vga_sync_gen #(
    .TOTAL_COLS   (TC),
    .TOTAL_ROWS   (TR),
    .ACTIVE_COLS  (AC),
    .ACTIVE_ROWS  (AR),
    .H_FRONT_PORCH(HFP),
    .H_SYNC_WIDTH (HSW),
    .V_FRONT_PORCH(VFP),
    .V_SYNC_WIDTH (VSW),
    .CNT_W        (CW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .o_Col_Count(col),
    .o_Row_Count(row),
    .o_H_Active (ha),
    .o_V_Active (va),
    .o_H_Sync   (hs),
    .o_V_Sync   (vs)
  );

  always #20 CLK = ~CLK;

  typedef struct packed {
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          ha;
    logic          va;
    logic          hs;
    logic          vs;
  } pix_t;

  pix_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   idx    = 0;

  // Reference: position is a linear pixel index within the frame.
  function automatic pix_t ref_pix(input int p);
    int   c;
    int   r;
    pix_t e;
    c     = p % TC;
    r     = p / TC;
    e.col = c[CW-1:0];
    e.row = r[CW-1:0];
    e.ha  = (c < AC);
    e.va  = (r < AR);
    e.hs  = !(c >= AC + HFP && c < AC + HFP + HSW);
    e.vs  = !(r >= AR + VFP && r < AR + VFP + VSW);
    return e;
  endfunction

  // Drive RST for the next rising edge and queue the pixel it must produce.
  task automatic step(input logic rst_in);
    RST = rst_in;
    if (rst_in) idx = 0;
    else        idx = (idx + 1) % FRAME;
    exp_q.push_back(ref_pix(idx));
    @(negedge CLK);
  endtask

  // Monitor state
  int   cyc     = 0;
  int   last_hf = -1;
  int   last_vf = -1;
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;
  pix_t got;
  pix_t e;

  initial begin
    forever begin
      @(posedge CLK);
      #5;
      cyc++;
      got = {col, row, ha, va, hs, vs};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel cyc=%0d no expectation queued, got col=%0d row=%0d", cyc, col, row);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL pixel cyc=%0d got col=%0d row=%0d ha=%b va=%b hs=%b vs=%b exp col=%0d row=%0d ha=%b va=%b hs=%b vs=%b",
                   cyc, col, row, ha, va, hs, vs, e.col, e.row, e.ha, e.va, e.hs, e.vs);
        end
      end
      if (RST) begin
        last_hf = -1;
        last_vf = -1;
      end else begin
        if (prev_hs && !hs) begin
          if (last_hf >= 0) begin
            checks++;
            if (cyc - last_hf != TC) begin
              errors++;
              $display("FAIL hsync_period cyc=%0d got %0d clocks exp %0d", cyc, cyc - last_hf, TC);
            end
          end
          last_hf = cyc;
        end
        if (prev_vs && !vs) begin
          if (last_vf >= 0) begin
            checks++;
            if (cyc - last_vf != FRAME) begin
              errors++;
              $display("FAIL vsync_period cyc=%0d got %0d clocks exp %0d", cyc, cyc - last_vf, FRAME);
            end
          end
          last_vf = cyc;
        end
      end
      prev_hs = hs;
      prev_vs = vs;
    end
  end

  initial begin
    RST = 1'b1;
    // Held reset, then release: first free edge must give col=1.
    repeat (3) step(1'b1);
    // Two full frames plus a little, uninterrupted.
    repeat (2 * FRAME + 37) step(1'b0);
    // Reset inside both sync pulses (col 86, row 43).
    while (idx != 43 * TC + 86) step(1'b0);
    step(1'b1);
    repeat (300) step(1'b0);
    // Randomized sparse reset bursts.
    for (int n = 0; n < 12000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        repeat ($urandom_range(1, 4)) step(1'b1);
      end else begin
        step(1'b0);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA raster timing generator: free-running column/row counters with raw active-video flags, plus porch-shaped horizontal and vertical sync pulses for the monitor. It sits between the pixel clock and the pixel-data pipeline. Downstream logic uses the counts and active flags to fetch pixels; the sync outputs drive the VGA connector. Defaults are the 640x480 @ 60 Hz mode with a 25 MHz pixel clock (40 ns period).

## Interface
Parameters:
- TOTAL_COLS, 800, pixel clocks per line
- TOTAL_ROWS, 525, lines per frame
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- H_FRONT_PORCH, 16, clocks from end of active video to H sync start
- H_SYNC_WIDTH, 96, H sync pulse length in clocks
- V_FRONT_PORCH, 10, lines from end of active video to V sync start
- V_SYNC_WIDTH, 2, V sync pulse length in lines
- CNT_W, 10, counter width; must hold TOTAL_COLS-1 and TOTAL_ROWS-1

Ports:
- CLK  in  1  pixel clock; all logic on the rising edge
- RST  in  1  reset, synchronous, active-high
- o_Col_Count  out  CNT_W  current column, 0..TOTAL_COLS-1
- o_Row_Count  out  CNT_W  current row, 0..TOTAL_ROWS-1
- o_H_Active  out  1  high while o_Col_Count < ACTIVE_COLS (raw H pulse)
- o_V_Active  out  1  high while o_Row_Count < ACTIVE_ROWS (raw V pulse)
- o_H_Sync  out  1  porched horizontal sync, active-low
- o_V_Sync  out  1  porched vertical sync, active-low

Back porches are implicit: H back porch is TOTAL_COLS - ACTIVE_COLS - H_FRONT_PORCH - H_SYNC_WIDTH (48). V back porch is the same formula on rows (33).

## Operation
- Column counter increments every clock. At TOTAL_COLS-1 it wraps to 0.
- Row counter increments only on the column wrap (799->0). At TOTAL_ROWS-1 it wraps to 0 on that same edge, so frame wrap is 799/524 -> 0/0.
- Decode uses the current counts:
  - o_H_Active = (col < ACTIVE_COLS)
  - o_V_Active = (row < ACTIVE_ROWS)
  - o_H_Sync = 0 iff ACTIVE_COLS+H_FRONT_PORCH <= col < ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH, i.e. cols 656..751
  - o_V_Sync = 0 iff ACTIVE_ROWS+V_FRONT_PORCH <= row < ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH, i.e. rows 490..491; o_V_Sync is low for the full 800 clocks of each of those lines
- Every output is a flip-flop. The flag/sync registers are loaded from the decode of the next count values, so all outputs describe the same pixel in the same cycle. No output may glitch.
- Reset:
  - Counters go to 0/0.
  - o_H_Active=1, o_V_Active=1.
  - o_H_Sync=1, o_V_Sync=1 (deasserted).
  - These match the decode of position 0/0.
- Reset asserted mid-frame forces the reset state on the next edge and holds it while RST=1. Counting resumes from 0/0 on the first edge with RST=0. RST has priority over wrap.

## Timing
- Latency 0 between counter and flags: in any cycle, all six outputs correspond to (o_Col_Count, o_Row_Count).
- First edge with RST low after reset: col becomes 1.
- Line period: TOTAL_COLS clocks (32 us at 25 MHz).
- Frame period: TOTAL_COLS*TOTAL_ROWS = 420000 clocks (16.8 ms).
- o_H_Sync falls on the edge where col becomes 656 and rises on the edge where col becomes 752, giving 96 clocks low.
- o_H_Active falls on the edge where col becomes 640 and rises when col becomes 0.
- o_V_Sync falls on the edge entering row 490, col 0, and rises on the edge entering row 492, col 0, giving 1600 clocks low.
- o_H_Sync keeps toggling every line during vertical blanking and V sync.

## Test plan
- Reset check: RST=1 for 3 clocks, then released. Required: held at col=0, row=0, H_Active=V_Active=1, H_Sync=V_Sync=1. Col=1 one edge after release.
- Horizontal line: run 800 clocks from 0/0. Required:
  - H_Active low exactly at cols 640..799
  - H_Sync low exactly at cols 656..751 (96 clocks)
  - col wraps 799->0 with row 0->1 on the same edge
- Vertical frame: run 420000 clocks. Required:
  - V_Active low exactly at rows 480..524
  - V_Sync low exactly at rows 490..491 (1600 consecutive clocks)
  - wrap 799/524 -> 0/0
  - second frame identical
- Sync period: measure successive o_H_Sync falling edges. Required: 800 clocks apart (32000 ns at 40 ns clock). Successive o_V_Sync falling edges: 420000 clocks apart.
- Mid-frame reset: assert RST for 1 clock at col=700, row=490 (H_Sync low, V_Sync low). Required: next cycle 0/0 with both syncs high and both active flags high. Normal counting resumes afterwards.
